res_port_arbiter: RTL and testbench

- Shares the single result-memory port (res_rd/res_wr/res_addr/res_do/res_di) between NREQ requesters: image loader, forward pass and backward pass.
- Phase engines issue one-beat access requests. The arbiter grants one requester per cycle, drives the RAM port and routes read data back.
- A lock lets a requester hold the port for a neighbourhood read burst plus write-back without interleaving.
- A lock-length cap prevents starvation.

---
 rtl/dt_pkg.sv | 29 ++
 rtl/res_port_arbiter_rr_pick.sv | 42 ++++
 rtl/res_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_res_port_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared definitions for the result-memory datapath: requester indices,
// arbiter state encoding and the default result-memory geometry used by the
// loader, the pass engines and the port arbiter.
package dt_pkg;

  // Requester indices on the result-memory port; index 0 wins ties after reset.
  localparam int REQ_INIT = 0;
  localparam int REQ_FWD  = 1;
  localparam int REQ_BWD  = 2;

  // Geometry shared with the loader and pass engines.
  localparam int AW_DEF   = 14;
  localparam int DW_DEF   = 8;

  // Requester index width; the owner port is 2 bits, so up to 4 requesters.
  localparam int REQ_IW   = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Modulo-n increment for a requester index; n need not be a power of two.
  function automatic logic [REQ_IW-1:0] wrap_inc(input logic [REQ_IW-1:0] i,
                                                 input int n);
    return (int'(i) >= n - 1) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/res_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-one finder.
// Searches req starting at ptr, wrapping modulo N, and returns the first
// requester found as a one-hot vector and as an index.
//   req  in  N    request vector
//   ptr  in  IW   search start index (must be < N)
//   gnt  out N    one-hot winner, 0 when no request
//   idx  out IW   winner index, 0 when no request
//   any  out 1    some request present
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   j;
  logic [IW-1:0] jt;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    jt  = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtract is a full modulo.
      j = {1'b0, ptr} + (IW+1)'(k);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      jt = j[IW-1:0];
      if (!any && req[jt]) begin
        any     = 1'b1;
        gnt[jt] = 1'b1;
        idx     = jt;
      end
    end
  end

endmodule

// File: rtl/res_port_arbiter.sv
// res_port_arbiter: shares the single result-memory port between the image
// loader, forward pass and backward pass. One beat is granted per cycle and
// performed in that same cycle; read data returns one cycle later with a
// one-hot rvalid. A requester may lock the port for a burst; the lock is
// capped at MAX_LOCK cycles so the others cannot starve.
//   clk, reset      clock, asynchronous active-low reset
//   req/wr/lock     per-requester request, beat type (1=write), keep-port
//   addr/wdata      packed per-requester address / write data
//   gnt             one-hot grant (combinational)
//   rvalid, rdata   one-hot read return, read data (= res_di)
//   owner, locked   current lock owner (0 when unlocked), lock active
//   res_*           RAM port; res_di valid the cycle after res_rd
module res_port_arbiter
  import dt_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   wr,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic [1:0]        owner,
  output logic              locked,
  output logic              res_rd,
  output logic              res_wr,
  output logic [AW-1:0]     res_addr,
  output logic [DW-1:0]     res_do,
  input  logic [DW-1:0]     res_di
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_e          state_q, state_d;
  logic [REQ_IW-1:0]   rr_q, rr_d;
  logic [REQ_IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]     rvalid_q;

  logic [NREQ-1:0]         pick_gnt;
  logic [REQ_IW-1:0]       pick_idx;
  logic                    pick_any;
  logic [NREQ-1:0]         gnt_c;
  logic [NREQ-1:0]         own_oh;
  logic                    own_lock;

  logic [NREQ-1:0][AW-1:0] addr_a;
  logic [NREQ-1:0][DW-1:0] wdata_a;
  logic [AW-1:0]           addr_m;
  logic [DW-1:0]           wd_m;
  logic                    wr_m;
  logic                    any_g;

  assign addr_a  = addr;
  assign wdata_a = wdata;

  rr_pick #(.N(NREQ), .IW(REQ_IW)) u_pick (
    .req (req),
    .ptr (rr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_oh   = NREQ'(1) << owner_q;
  assign own_lock = |(lock & own_oh);

  // Next state, pointer and lock counter.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_c   = '0;
    unique case (state_q)
      ARB: begin
        gnt_c = pick_gnt;
        if (pick_any) begin
          rr_d = wrap_inc(pick_idx, NREQ);
          if (lock[pick_idx]) begin
            state_d = LOCK;
            owner_d = pick_idx;
            cnt_d   = CW'(1);
          end
        end
      end
      LOCK: begin
        // Only the owner may use the port; its idle cycles still count.
        gnt_c = req & own_oh;
        if (!own_lock || cnt_q == CW'(MAX_LOCK)) begin
          state_d = ARB;
          cnt_d   = '0;
          rr_d    = wrap_inc(owner_q, NREQ);
          owner_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Grant is combinational, so gate it with reset to keep the RAM port
  // quiet for the whole time reset is held, not just after the next edge.
  assign gnt = reset ? gnt_c : '0;

  // One-hot AND-OR mux of the winning requester onto the RAM port.
  always_comb begin
    addr_m = '0;
    wd_m   = '0;
    wr_m   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        addr_m = addr_m | addr_a[i];
        wd_m   = wd_m   | wdata_a[i];
        wr_m   = wr_m   | wr[i];
      end
    end
  end

  assign any_g    = |gnt;
  assign res_wr   = any_g & wr_m;
  assign res_rd   = any_g & ~wr_m;
  assign res_addr = addr_m;
  assign res_do   = res_wr ? wd_m : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB;
      rr_q     <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt & ~wr;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = res_di;
  assign owner  = owner_q;
  assign locked = (state_q == LOCK);

endmodule

// File: tb/tb_res_port_arbiter.sv
module tb_res_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 14;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, wr, lock;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic [1:0]        owner;
  logic              locked;
  logic              res_rd, res_wr;
  logic [AW-1:0]     res_addr;
  logic [DW-1:0]     res_do, res_di;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  res_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .owner(owner), .locked(locked), .res_rd(res_rd), .res_wr(res_wr),
    .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
  );

  task automatic idle_inputs();
    req = '0; wr = '0; lock = '0; addr = '0; wdata = '0; res_di = '0;
  endtask

  // Reset asserted and released away from the rising edge.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    req = 3'b111;
    addr = {14'd3, 14'd2, 14'd1};
    repeat (2) @(negedge clk);
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt); end
    checks++; if (res_rd !== 1'b0 || res_wr !== 1'b0) begin errors++; $display("FAIL reset_strobe got rd=%b wr=%b want 0 0", res_rd, res_wr); end
    checks++; if (res_addr !== 14'd0 || res_do !== 8'd0) begin errors++; $display("FAIL reset_port got addr=%0d do=%h want 0 0", res_addr, res_do); end
    checks++; if (rvalid !== 3'b000 || locked !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL reset_state got rv=%b lk=%b own=%0d want 000 0 0", rvalid, locked, owner); end
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #1;
    checks++; if (gnt !== 3'b000 || res_rd !== 1'b0 || res_addr !== 14'd0) begin errors++; $display("FAIL idle_port got gnt=%b rd=%b addr=%0d want 000 0 0", gnt, res_rd, res_addr); end
  endtask

  task automatic test_single();
    apply_reset();
    @(negedge clk);
    req = 3'b010; wr = 3'b000;
    addr = '0; addr[1*AW +: AW] = 14'd129;
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL single_gnt got %b want 010", gnt); end
    checks++; if (res_rd !== 1'b1 || res_wr !== 1'b0) begin errors++; $display("FAIL single_strobe got rd=%b wr=%b want 1 0", res_rd, res_wr); end
    checks++; if (res_addr !== 14'd129) begin errors++; $display("FAIL single_addr got %0d want 129", res_addr); end
    @(negedge clk);
    req = '0; res_di = 8'd5;
    #1;
    checks++; if (rvalid !== 3'b010) begin errors++; $display("FAIL single_rvalid got %b want 010", rvalid); end
    checks++; if (rdata !== 8'd5) begin errors++; $display("FAIL single_rdata got %0d want 5", rdata); end
    @(negedge clk);
    #1;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL single_rvalid_once got %b want 000", rvalid); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req = 3'b111; wr = 3'b000;
      #1;
      checks++; if (gnt !== exp_g[k]) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, exp_g[k]); end
      if (k > 0) begin
        checks++; if (rvalid !== exp_g[k-1]) begin errors++; $display("FAIL rr_rvalid[%0d] got %b want %b", k, rvalid, exp_g[k-1]); end
      end
    end
    @(negedge clk);
    req = '0;
    #1;
    checks++; if (rvalid !== 3'b100) begin errors++; $display("FAIL rr_rvalid_last got %b want 100", rvalid); end
  endtask

  task automatic test_lock_burst();
    apply_reset();
    // Move the pointer to 1 with a plain read from requester 0.
    @(negedge clk);
    req = 3'b001; wr = '0; lock = '0;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL burst_pre_gnt got %b want 001", gnt); end
    wdata = '0; wdata[1*DW +: DW] = 8'hA5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req  = 3'b111;
      lock = (k < 4) ? 3'b010 : 3'b000;
      wr   = (k < 4) ? 3'b000 : 3'b010;
      #1;
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL burst_gnt[%0d] got %b want 010", k, gnt); end
      if (k > 0) begin
        checks++; if (locked !== 1'b1 || owner !== 2'd1) begin errors++; $display("FAIL burst_lock[%0d] got lk=%b own=%0d want 1 1", k, locked, owner); end
      end
      if (k == 4) begin
        checks++; if (res_wr !== 1'b1 || res_rd !== 1'b0 || res_do !== 8'hA5) begin errors++; $display("FAIL burst_wb got wr=%b rd=%b do=%h want 1 0 a5", res_wr, res_rd, res_do); end
      end
    end
    @(negedge clk);
    req = 3'b111; lock = '0; wr = '0;
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL burst_after_gnt got %b want 100", gnt); end
    checks++; if (locked !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL burst_release got lk=%b own=%0d want 0 0", locked, owner); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL burst_wb_rvalid got %b want 000", rvalid); end
  endtask

  task automatic test_forced_release();
    apply_reset();
    @(negedge clk);
    req = 3'b100; lock = 3'b100; wr = '0;
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL force_enter_gnt got %b want 100", gnt); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req = 3'b101; lock = 3'b100;
      #1;
      checks++; if (gnt !== 3'b100 || locked !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL force_hold[%0d] got gnt=%b lk=%b own=%0d want 100 1 2", k, gnt, locked, owner); end
    end
    @(negedge clk);
    #1;
    checks++; if (gnt !== 3'b001 || locked !== 1'b0) begin errors++; $display("FAIL force_release got gnt=%b lk=%b want 001 0", gnt, locked); end
    @(negedge clk);
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL force_rewin got %b want 100", gnt); end
  endtask

  task automatic test_write();
    apply_reset();
    @(negedge clk);
    req = 3'b001; wr = 3'b001; lock = '0;
    addr = '0; addr[0 +: AW] = 14'd16255;
    wdata = '0; wdata[0 +: DW] = 8'h7F;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL write_gnt got %b want 001", gnt); end
    checks++; if (res_wr !== 1'b1 || res_rd !== 1'b0) begin errors++; $display("FAIL write_strobe got wr=%b rd=%b want 1 0", res_wr, res_rd); end
    checks++; if (res_do !== 8'h7F || res_addr !== 14'd16255) begin errors++; $display("FAIL write_port got do=%h addr=%0d want 7f 16255", res_do, res_addr); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL write_rvalid got %b want 000", rvalid); end
    checks++; if (res_do !== 8'h00 || res_wr !== 1'b0) begin errors++; $display("FAIL write_idle got do=%h wr=%b want 00 0", res_do, res_wr); end
  endtask

  task automatic test_reset_mid_lock();
    apply_reset();
    @(negedge clk);
    req = 3'b010; lock = 3'b010; wr = '0;
    addr = '0; addr[1*AW +: AW] = 14'd77;
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL midrst_gnt got %b want 010", gnt); end
    @(negedge clk);
    #1;
    checks++; if (locked !== 1'b1 || rvalid !== 3'b010) begin errors++; $display("FAIL midrst_locked got lk=%b rv=%b want 1 010", locked, rvalid); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000 || res_rd !== 1'b0 || res_wr !== 1'b0) begin errors++; $display("FAIL midrst_port got gnt=%b rd=%b wr=%b want 000 0 0", gnt, res_rd, res_wr); end
    checks++; if (rvalid !== 3'b000 || locked !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL midrst_state got rv=%b lk=%b own=%0d want 000 0 0", rvalid, locked, owner); end
    @(negedge clk);
    reset = 1'b1;
    req = 3'b111; lock = '0; wr = '0;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL midrst_first_gnt got %b want 001", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL midrst_no_rvalid got %b want 000", rvalid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock_burst();
    test_forced_release();
    test_write();
    test_reset_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
